prog_fetch: RTL
===============

Name: prog_fetch

Overview:
Instruction-byte fetch stage that sits directly upstream of the program ROM.
- Drives the ROM's active-low chip select and 16-bit address, and samples its combinational 8-bit data.
- Buffers fetched bytes, each tagged with its address, in a small prefetch FIFO.
- Hands bytes to the decoder over a valid/ready stream.
- Supports start, halt and jump (PC load with flush).

Parameters:
FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.
RESET_PC, 16'h0000, PC value after reset.
PARK_ADDR, 16'hFFFF, address driven while idle or halted; never fetched.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  pulse; begins fetching (IDLE) or resumes it (HALT).
halt_req  input  1  pulse; stops fetching at the next edge.
load_pc  input  1  pulse; jump to load_addr and flush the FIFO.
load_addr  input  16  jump target.
rom_cs_n  output  1  ROM chip select, active low.
rom_addr  output  16  ROM address, registered.
rom_data  input  8  ROM read data, combinational from rom_addr.
out_valid  output  1  FIFO head holds a valid byte.
out_data  output  8  byte at the FIFO head.
out_addr  output  16  address of out_data.
out_ready  input  1  decoder accepts the head byte this cycle.
busy  output  1  high while state is FETCH.

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, rom_addr=PARK_ADDR, rom_cs_n=1, FIFO empty, out_valid=0, out_data=0, out_addr=0, busy=0.
- States: IDLE, FETCH, HALT. The encoding lives in the package.
- IDLE:
  - rom_cs_n=1, rom_addr=PARK_ADDR.
  - start -> FETCH with rom_addr<=pc and rom_cs_n<=0.
  - load_pc sets pc and stays in IDLE.
- ROM sensitivity: the ROM updates data only on an address change, and only while cs is low. Parking at PARK_ADDR guarantees an address event on every entry to FETCH. rom_cs_n stays 0 for the whole time in FETCH.
- FETCH:
  - rom_addr always equals pc.
  - A push occurs in a cycle when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - On a push: {rom_addr, rom_data} is written, and pc and rom_addr advance by 1.
  - With no push: pc and rom_addr hold.
  - Throughput is 1 byte/cycle.
- Latency: start asserted in cycle 0 -> rom_addr valid in cycle 1 -> first push at the end of cycle 1 -> out_valid=1 in cycle 2.
- PC increment: 16'hFFFE -> 16'h0000, skipping PARK_ADDR. A load_addr of PARK_ADDR is treated as 16'h0000.
- Output stream:
  - A pop occurs on out_valid && out_ready.
  - out_data and out_addr hold stable while out_valid && !out_ready.
  - Push and pop are permitted in the same cycle, both at full and at empty.
  - With the FIFO empty, a push is visible only from the next cycle; there is no bypass.
- load_pc in FETCH or HALT:
  - The FIFO is flushed, so out_valid=0 in the next cycle.
  - pc<=load_addr and rom_addr<=load_addr.
  - No push occurs that cycle, and the pop is ignored.
  - Next state is FETCH.
- halt_req in FETCH:
  - No push that cycle; next state HALT; rom_cs_n<=1, rom_addr<=PARK_ADDR.
  - pc keeps the next unfetched address.
  - FIFO contents remain drainable.
- HALT:
  - start -> FETCH, resuming at pc.
  - halt_req is ignored.
- Simultaneous events:
  - load_pc + halt_req: the flush and pc load apply, and the next state is HALT.
  - start + halt_req in IDLE: start wins.
  - start in FETCH is ignored.
- Reset asserted mid-operation: all state and outputs return immediately to their reset values, whatever the handshake state.

Decomposition:
- Package prog_fetch_pkg: state enum (IDLE, FETCH, HALT), default PARK_ADDR, default RESET_PC, FIFO entry width constant (24).
- Sub-module prog_fetch_fifo: synchronous FIFO of {addr[15:0], data[7:0]}.
  - Ports: push, pop, flush, full, empty, head outputs.
  - flush has priority over push and pop.

Test Plan:
- ROM model bytes 0000:07, 0001:C0, 0002:40, 0003:C1; reset, start at cycle 0, out_ready=1 -> out_valid rises in cycle 2; stream (0000,07),(0001,C0),(0002,40),(0003,C1) on consecutive cycles.
- out_ready=0 after start -> FIFO holds 4 entries; pc and rom_addr stall at 0004; head stays (0000,07); raising out_ready resumes at 1 byte/cycle with no loss or duplication.
- load_pc=1, load_addr=0002 while the FIFO is full -> out_valid=0 next cycle; first byte after the jump is (0002,40).
- halt_req after 2 pushes -> rom_cs_n=1, rom_addr=FFFF; queued bytes drain; start resumes at (0002,40).
- load_pc to FFFE, then keep fetching -> addresses FFFE then 0000, never FFFF; load_addr=FFFF -> first byte at 0000.
- rst pulsed mid-stream with out_valid=1 -> out_valid=0, rom_addr=FFFF, rom_cs_n=1, busy=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/prog_fetch_pkg.sv
// Shared types and constants for the program-byte fetch stage.
package prog_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [15:0] PARK_ADDR_DEF = 16'hFFFF;
  localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
  localparam int          ENTRY_W       = 24;

  // The park address is never fetched, so the increment steps over it.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc, input logic [15:0] park);
    logic [15:0] n;
    n = pc + 16'd1;
    if (n == park) n = n + 16'd1;
    return n;
  endfunction

  function automatic logic [15:0] pc_fix(input logic [15:0] a, input logic [15:0] park);
    return (a == park) ? 16'h0000 : a;
  endfunction

endpackage

// File: rtl/prog_fetch_fifo.sv
// Prefetch FIFO of {addr, data} entries; flush overrides push and pop.
module prog_fetch_fifo
  import prog_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic               push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/prog_fetch.sv
// Instruction-byte fetch: drives the program ROM and streams tagged bytes to the decoder.
// state | meaning
// IDLE  | parked, cs high, waiting for start
// FETCH | cs low, rom_addr tracks pc, one push per cycle when space allows
// HALT  | parked, FIFO still drains, start resumes at pc
module prog_fetch
  import prog_fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [15:0] PARK_ADDR  = PARK_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        load_pc,
  input  logic [15:0] load_addr,
  output logic        rom_cs_n,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [15:0] out_addr,
  input  logic        out_ready,
  output logic        busy
);

  state_t       state, state_nxt;
  logic [15:0]  pc, pc_nxt, addr_nxt, tgt;
  logic         cs_n_nxt, push, pop, flush, full, empty;
  logic [ENTRY_W-1:0] head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      rom_addr <= PARK_ADDR;
      rom_cs_n <= 1'b1;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      rom_addr <= addr_nxt;
      rom_cs_n <= cs_n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = rom_addr;
    cs_n_nxt  = rom_cs_n;
    push      = 1'b0;
    flush     = 1'b0;
    pop       = out_valid && out_ready;
    tgt       = load_pc ? pc_fix(load_addr, PARK_ADDR) : pc;
    case (state)
      IDLE: begin
        addr_nxt = PARK_ADDR;
        cs_n_nxt = 1'b1;
        pc_nxt   = tgt;
        if (start) begin
          state_nxt = FETCH;
          addr_nxt  = tgt;
          cs_n_nxt  = 1'b0;
        end
      end
      FETCH: begin
        if (load_pc || halt_req) begin
          flush    = load_pc;
          pop      = pop && !load_pc;
          pc_nxt   = tgt;
          addr_nxt = tgt;
          if (halt_req) begin
            state_nxt = HALT;
            addr_nxt  = PARK_ADDR;
            cs_n_nxt  = 1'b1;
          end
        end else begin
          push = !full || pop;
          if (push) begin
            pc_nxt   = pc_inc(pc, PARK_ADDR);
            addr_nxt = pc_inc(pc, PARK_ADDR);
          end
        end
      end
      HALT: begin
        addr_nxt = PARK_ADDR;
        cs_n_nxt = 1'b1;
        pc_nxt   = tgt;
        flush    = load_pc;
        pop      = pop && !load_pc;
        // load with halt stays halted; start always resumes
        if (start || (load_pc && !halt_req)) begin
          state_nxt = FETCH;
          addr_nxt  = tgt;
          cs_n_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  prog_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({rom_addr, rom_data}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign out_valid = !empty;
  assign out_data  = head[7:0];
  assign out_addr  = head[23:8];
  assign busy      = (state == FETCH);

endmodule
